pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline interface controller; successor to the single-EX/MA hazard unit.

---
 rtl/pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline interface controller.
// Resolves ID operand hazards against FWD_DEPTH forwarding stages (stage 0 = EX),
// stalls on results that are not yet ready, redirects the PC on EX control-flow
// mismatch, freezes everything while data memory is busy, and drains the pipe into
// a HALTED state on an EX HALT until resume.
// Optional feature macro: PIC_PERF_EN adds saturating stall/flush cycle counters.

// Single-stage, single-operand hazard detector.
module pipe_hazard_match #(
    parameter int RID_W = 5
) (
    input  logic             rd,
    input  logic [RID_W-1:0] req,
    input  logic             we,
    input  logic [RID_W-1:0] req_w,
    output logic             hit
);
    // r0 is hardwired, so a read of r0 never depends on an in-flight write
    assign hit = rd && (req != '0) && we && (req_w == req);
endmodule

module pipe_hazard_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int RID_W     = 5,
    parameter int FWD_DEPTH = 3,
    parameter int MUX_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          id_pc,
    input  logic                       id_rf_ra,
    input  logic                       id_rf_rb,
    input  logic [RID_W-1:0]           id_rf_req_a,
    input  logic [RID_W-1:0]           id_rf_req_b,
    input  logic [FWD_DEPTH-1:0]       st_rf_we,
    input  logic [FWD_DEPTH*RID_W-1:0] st_rf_req_w,
    input  logic [FWD_DEPTH-1:0]       st_ready,
    input  logic                       ex_valid,
    input  logic [ADDR_W-1:0]          ex_pc_4,
    input  logic                       ex_is_jump,
    input  logic                       ex_branched,
    input  logic [ADDR_W-1:0]          ex_wtg_pc_new,
    input  logic                       ex_halt,
    input  logic                       dm_busy,
    input  logic                       resume,
    output logic                       pc_en,
    output logic                       pc_ld,
    output logic [ADDR_W-1:0]          pc_ld_addr,
    output logic                       ifid_en,
    output logic                       ifid_nop,
    output logic                       idex_en,
    output logic                       idex_nop,
    output logic [MUX_W-1:0]           id_mux_fwd_rf_a,
    output logic [MUX_W-1:0]           id_mux_fwd_rf_b,
    output logic                       halted
`ifdef PIC_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_flush_cnt
`endif
);
    localparam int CNT_W = (FWD_DEPTH > 1) ? $clog2(FWD_DEPTH) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t             state;
    logic [CNT_W-1:0]   drain_cnt;
    logic [FWD_DEPTH-1:0] hit_a, hit_b;
    logic               stall_a, stall_b, stall;
    logic [ADDR_W-1:0]  pc_correct;
    logic               redirect, halt_go;

    for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_stage
        pipe_hazard_match #(.RID_W(RID_W)) u_match_a (
            .rd(id_rf_ra), .req(id_rf_req_a), .we(st_rf_we[k]),
            .req_w(st_rf_req_w[k*RID_W +: RID_W]), .hit(hit_a[k])
        );
        pipe_hazard_match #(.RID_W(RID_W)) u_match_b (
            .rd(id_rf_rb), .req(id_rf_req_b), .we(st_rf_we[k]),
            .req_w(st_rf_req_w[k*RID_W +: RID_W]), .hit(hit_b[k])
        );
    end

    // Youngest matching stage wins: scan oldest-first so the lowest k is assigned last
    always_comb begin
        id_mux_fwd_rf_a = '0;
        id_mux_fwd_rf_b = '0;
        stall_a = 1'b0;
        stall_b = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (hit_a[k]) begin
                id_mux_fwd_rf_a = MUX_W'(k + 1);
                stall_a = !st_ready[k];
            end
            if (hit_b[k]) begin
                id_mux_fwd_rf_b = MUX_W'(k + 1);
                stall_b = !st_ready[k];
            end
        end
        stall = stall_a || stall_b;
    end

    // Pipeline register controls; freeze > halt/drain squash > redirect > load-use stall
    always_comb begin
        pc_correct = (ex_is_jump || ex_branched) ? ex_wtg_pc_new : ex_pc_4;
        redirect   = ex_valid && (id_pc != pc_correct);
        halt_go    = ex_valid && ex_halt;
        pc_ld_addr = pc_correct;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        pc_ld      = 1'b0;
        ifid_nop   = 1'b0;
        idex_nop   = 1'b0;
        if (dm_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (halt_go) begin
                        pc_en    = 1'b0;
                        ifid_nop = 1'b1;
                        idex_nop = 1'b1;
                    end else if (redirect) begin
                        pc_ld    = 1'b1;
                        ifid_nop = 1'b1;
                        idex_nop = 1'b1;
                    end else if (stall) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_nop = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_en    = 1'b0;
                    ifid_nop = 1'b1;
                    idex_nop = 1'b1;
                end
                default: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_nop = 1'b1;
                end
            endcase
        end
    end

    // Halt FSM: RUN -> DRAIN (FWD_DEPTH cycles) -> HALTED -> RUN on resume; frozen while dm_busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else if (!dm_busy) begin
            case (state)
                S_RUN: begin
                    if (halt_go) begin
                        if (FWD_DEPTH == 1) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= CNT_W'(FWD_DEPTH - 1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_HALTED: begin
                    if (resume) begin
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIC_PERF_EN
    logic stall_evt, flush_evt;
    assign stall_evt = !dm_busy && (state == S_RUN) && !halt_go && !redirect && stall;
    assign flush_evt = !dm_busy && (state == S_RUN) && !halt_go && redirect;

    // Saturating counters of effective load-use stall and redirect cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_evt && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_evt && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a cycle-level reference model of the
// hazard controller plus literal spot checks. Build with PIC_PERF_EN to cover counters.
module tb_pipe_hazard_ctrl;
    localparam int ADDR_W = 10, RID_W = 5, FWD_DEPTH = 3, MUX_W = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [ADDR_W-1:0] id_pc, ex_pc_4, ex_wtg_pc_new, pc_ld_addr;
    logic id_rf_ra, id_rf_rb, ex_valid, ex_is_jump, ex_branched, ex_halt, dm_busy, resume;
    logic [RID_W-1:0] id_rf_req_a, id_rf_req_b;
    logic [FWD_DEPTH-1:0] st_rf_we, st_ready;
    logic [FWD_DEPTH*RID_W-1:0] st_rf_req_w;
    logic pc_en, pc_ld, ifid_en, ifid_nop, idex_en, idex_nop, halted;
    logic [MUX_W-1:0] id_mux_fwd_rf_a, id_mux_fwd_rf_b;
`ifdef PIC_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int n_vec = 0, n_bad = 0;

    pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .RID_W(RID_W), .FWD_DEPTH(FWD_DEPTH), .MUX_W(MUX_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_rf_ra(id_rf_ra), .id_rf_rb(id_rf_rb),
        .id_rf_req_a(id_rf_req_a), .id_rf_req_b(id_rf_req_b), .st_rf_we(st_rf_we),
        .st_rf_req_w(st_rf_req_w), .st_ready(st_ready), .ex_valid(ex_valid), .ex_pc_4(ex_pc_4),
        .ex_is_jump(ex_is_jump), .ex_branched(ex_branched), .ex_wtg_pc_new(ex_wtg_pc_new),
        .ex_halt(ex_halt), .dm_busy(dm_busy), .resume(resume), .pc_en(pc_en), .pc_ld(pc_ld),
        .pc_ld_addr(pc_ld_addr), .ifid_en(ifid_en), .ifid_nop(ifid_nop), .idex_en(idex_en),
        .idex_nop(idex_nop), .id_mux_fwd_rf_a(id_mux_fwd_rf_a), .id_mux_fwd_rf_b(id_mux_fwd_rf_b),
        .halted(halted)
`ifdef PIC_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: halted flag, DRAIN cycles still to run, perf counts
    bit          m_halted = 1'b0, n_halted = 1'b0;
    int          m_drain = 0, n_drain = 0;
    logic [31:0] m_stall = '0, m_flush = '0, n_stall = '0, n_flush = '0;

    // Operand lookup: first stage (lowest k) writing the register decides
    function automatic void lookup(input bit rd, input logic [RID_W-1:0] r, output int mux, output bit stl);
        mux = 0;
        stl = 1'b0;
        if (rd && r != 0)
            for (int k = 0; k < FWD_DEPTH; k++)
                if (st_rf_we[k] && st_rf_req_w[k*RID_W +: RID_W] == r) begin
                    mux = k + 1;
                    stl = !st_ready[k];
                    break;
                end
    endfunction

    // Compare every output against the model each cycle, then compute the model's next state
    always @(negedge clk) begin
        int ma, mb;
        bit sa, sb, stl, redir, hgo, running;
        logic [ADDR_W-1:0] tgt;
        bit e_pc_en, e_ifid_en, e_idex_en, e_pc_ld, e_ifid_nop, e_idex_nop;
        lookup(id_rf_ra, id_rf_req_a, ma, sa);
        lookup(id_rf_rb, id_rf_req_b, mb, sb);
        stl = sa | sb;
        tgt = (ex_is_jump | ex_branched) ? ex_wtg_pc_new : ex_pc_4;
        redir = ex_valid && (id_pc != tgt);
        hgo = ex_valid && ex_halt;
        running = !m_halted && m_drain == 0;
        {e_pc_en, e_ifid_en, e_idex_en, e_pc_ld, e_ifid_nop, e_idex_nop} = 6'b111_000;
        if (dm_busy)                  {e_pc_en, e_ifid_en, e_idex_en} = 3'b000;
        else if (m_halted)            {e_pc_en, e_ifid_en, e_idex_nop} = 3'b001;
        else if (m_drain > 0 || hgo)  {e_pc_en, e_ifid_nop, e_idex_nop} = 3'b011;
        else if (redir)               {e_pc_ld, e_ifid_nop, e_idex_nop} = 3'b111;
        else if (stl)                 {e_pc_en, e_ifid_en, e_idex_nop} = 3'b001;
        chk("pc_en", 32'(pc_en), 32'(e_pc_en));
        chk("ifid_en", 32'(ifid_en), 32'(e_ifid_en));
        chk("idex_en", 32'(idex_en), 32'(e_idex_en));
        chk("pc_ld", 32'(pc_ld), 32'(e_pc_ld));
        chk("ifid_nop", 32'(ifid_nop), 32'(e_ifid_nop));
        chk("idex_nop", 32'(idex_nop), 32'(e_idex_nop));
        if (e_pc_ld) chk("pc_ld_addr", 32'(pc_ld_addr), 32'(tgt));
        chk("mux_a", 32'(id_mux_fwd_rf_a), ma);
        chk("mux_b", 32'(id_mux_fwd_rf_b), mb);
        chk("halted", 32'(halted), 32'(m_halted));
`ifdef PIC_PERF_EN
        chk("perf_stall", perf_stall_cnt, m_stall);
        chk("perf_flush", perf_flush_cnt, m_flush);
`endif
        n_halted = m_halted; n_drain = m_drain; n_stall = m_stall; n_flush = m_flush;
        if (!dm_busy) begin
            if (m_halted) begin
                if (resume) n_halted = 1'b0;
            end else if (m_drain > 0) begin
                n_drain = m_drain - 1;
                if (n_drain == 0) n_halted = 1'b1;
            end else if (hgo) begin
                if (FWD_DEPTH == 1) n_halted = 1'b1;
                else n_drain = FWD_DEPTH;
            end
            if (running && !hgo && redir && m_flush != '1) n_flush = m_flush + 1;
            if (running && !hgo && !redir && stl && m_stall != '1) n_stall = m_stall + 1;
        end
    end

    // Commit the model at the clock edge; async reset clears it immediately
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halted <= 1'b0; m_drain <= 0; m_stall <= '0; m_flush <= '0;
        end else begin
            m_halted <= n_halted; m_drain <= n_drain; m_stall <= n_stall; m_flush <= n_flush;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_pc = 10'h10; ex_pc_4 = 10'h14; ex_wtg_pc_new = '0;
        id_rf_ra = 0; id_rf_rb = 0; id_rf_req_a = '0; id_rf_req_b = '0;
        st_rf_we = '0; st_ready = '0; st_rf_req_w = '0;
        ex_valid = 0; ex_is_jump = 0; ex_branched = 0; ex_halt = 0; dm_busy = 0; resume = 0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_pc_en", 32'(pc_en), 1);
        tick();
        rst_n = 1'b1;

        // 1: forwarding A from stage 0, then stage 1 when stage 0 writes another reg
        clr(); id_rf_ra = 1; id_rf_req_a = 5; st_rf_we = 3'b001; st_rf_req_w = {5'd0, 5'd0, 5'd5}; st_ready = 3'b001;
        @(negedge clk); chk("t1_mux_a_s0", 32'(id_mux_fwd_rf_a), 1); chk("t1_pc_en", 32'(pc_en), 1);
        tick(); st_rf_we = 3'b011; st_rf_req_w = {5'd0, 5'd5, 5'd3}; st_ready = 3'b011;
        @(negedge clk); chk("t1_mux_a_s1", 32'(id_mux_fwd_rf_a), 2);
        tick(); st_rf_we = 3'b111; st_rf_req_w = {5'd5, 5'd5, 5'd5}; st_ready = 3'b110;
        @(negedge clk); chk("t1_lowest_wins", 32'(idex_nop), 1);
        tick(); id_rf_req_a = 0; st_rf_req_w = '0; st_ready = 3'b111;
        @(negedge clk); chk("t1_r0", 32'(id_mux_fwd_rf_a), 0);
        tick(); id_rf_ra = 0; id_rf_req_a = 5; st_rf_req_w = {5'd0, 5'd0, 5'd5};
        @(negedge clk); chk("t1_noread", 32'(id_mux_fwd_rf_a), 0);

        // 2: load-use stall on B, released when the result becomes ready
        tick(); clr(); id_rf_rb = 1; id_rf_req_b = 7; st_rf_we = 3'b001; st_rf_req_w = {5'd0, 5'd0, 5'd7};
        @(negedge clk);
        chk("t2_pc_en", 32'(pc_en), 0); chk("t2_ifid_en", 32'(ifid_en), 0);
        chk("t2_idex_nop", 32'(idex_nop), 1); chk("t2_mux_b", 32'(id_mux_fwd_rf_b), 1);
        tick(); st_ready = 3'b001;
        @(negedge clk); chk("t2_mux_b_rdy", 32'(id_mux_fwd_rf_b), 1); chk("t2_release", 32'(pc_en), 1);

        // 3: redirect on taken branch and on fall-through mismatch
        tick(); clr(); ex_valid = 1; ex_branched = 1; ex_wtg_pc_new = 10'h40; id_pc = 10'h14; ex_pc_4 = 10'h18;
        @(negedge clk);
        chk("t3_pc_ld", 32'(pc_ld), 1); chk("t3_addr", 32'(pc_ld_addr), 32'h40);
        chk("t3_ifid_nop", 32'(ifid_nop), 1); chk("t3_idex_nop", 32'(idex_nop), 1);
        tick(); id_pc = 10'h40;
        @(negedge clk); chk("t3_match", 32'(pc_ld), 0);
        tick(); ex_branched = 0; id_pc = 10'h20;
        @(negedge clk); chk("t3_fall_addr", 32'(pc_ld_addr), 32'h18); chk("t3_fall_ld", 32'(pc_ld), 1);

        // 4: memory freeze over a stall plus redirect; stall remains afterwards
        tick(); clr(); id_rf_rb = 1; id_rf_req_b = 7; st_rf_we = 3'b001; st_rf_req_w = {5'd0, 5'd0, 5'd7};
        ex_valid = 1; ex_branched = 1; ex_wtg_pc_new = 10'h40; id_pc = 10'h14; dm_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_en", 32'({pc_en, ifid_en, idex_en}), 0);
            chk("t4_ld_nop", 32'({pc_ld, ifid_nop, idex_nop}), 0);
            tick();
        end
        dm_busy = 0; ex_valid = 0;
        @(negedge clk); chk("t4_stall_stays", 32'({pc_en, idex_nop}), 32'b01);

        // 5: halt beats redirect, drains 3 cycles, halts, freeze holds, resume returns to RUN
        tick(); clr(); ex_valid = 1; ex_halt = 1; ex_branched = 1; ex_wtg_pc_new = 10'h40; id_pc = 10'h14;
        @(negedge clk);
        chk("t5_no_ld", 32'(pc_ld), 0); chk("t5_sq", 32'({pc_en, ifid_nop, idex_nop}), 32'b011);
        tick(); clr(); resume = 1;
        @(negedge clk); chk("t5_d1", 32'({halted, pc_en, ifid_nop}), 32'b001);
        tick(); resume = 0;
        @(negedge clk); chk("t5_d2", 32'(halted), 0);
        tick();
        @(negedge clk); chk("t5_d3", 32'(halted), 0);
        tick();
        @(negedge clk);
        chk("t5_halted", 32'(halted), 1);
        chk("t5_h_ctl", 32'({pc_en, ifid_en, idex_nop}), 32'b001);
        dm_busy = 1; resume = 1;
        tick(); dm_busy = 0;
        @(negedge clk); chk("t5_busy_hold", 32'(halted), 1);
        tick(); resume = 0;
        @(negedge clk); chk("t5_resumed", 32'({halted, pc_en}), 32'b01);

        // 6: async reset in DRAIN
        tick(); clr(); ex_valid = 1; ex_halt = 1;
        tick(); clr();
        tick();
        @(negedge clk); chk("t6_draining", 32'(pc_en), 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pc_en", 32'(pc_en), 1); chk("t6_rst_halted", 32'(halted), 0);
        tick();
        rst_n = 1'b1;

`ifdef PIC_PERF_EN
        clr(); id_rf_rb = 1; id_rf_req_b = 7; st_rf_we = 3'b001; st_rf_req_w = {5'd0, 5'd0, 5'd7};
        repeat (4) tick();
        clr(); ex_valid = 1; ex_branched = 1; ex_wtg_pc_new = 10'h40; id_pc = 10'h14;
        repeat (2) tick();
        clr();
        @(negedge clk);
        chk("t6_perf_stall", perf_stall_cnt, 4);
        chk("t6_perf_flush", perf_flush_cnt, 2);
`endif
        tick(); tick();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
